pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter with a hardware return-address stack. It is the next-generation PC for the patp core: it adds increment, relative branch, absolute jump, call and return to the plain load-or-hold counter, at configurable address width and stack depth. The core's fetch stage reads `pc` as the instruction-memory address, and decode drives `op`, `target` and `offset`.

## Interface
- `AW`, default 5: address width in bits.
- `DEPTH`, default 4: number of return-stack entries, ≥1.
- `RESET_ADDR`, default 0: value loaded into `pc` on reset, AW bits.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: reset; asynchronous, active-high.
- `en` input, 1: advance enable; 0 = stall, nothing changes.
- `op` input, 3: operation select (see Operation).
- `target` input, AW: absolute address for JMP/CALL.
- `offset` input, AW: two's-complement displacement for BR.
- `clr_err` input, 1: synchronous clear of the sticky error flags.
- `pc` output, AW: current program counter, registered.
- `sp` output, $clog2(DEPTH+1): number of valid stack entries, registered.
- `stack_ovf` output, 1: sticky; CALL attempted while the stack was full.
- `stack_unf` output, 1: sticky; RET attempted while the stack was empty.

## Operation
- Opcodes: 0 INC, 1 JMP, 2 BR, 3 CALL, 4 RET, 5 HOLD. Codes 6 and 7 are reserved and behave as HOLD.
- INC: `pc` ← `pc`+1 mod 2^AW. The all-ones value wraps to 0.
- JMP: `pc` ← `target`.
- BR: `pc` ← `pc`+`offset` mod 2^AW. `offset` is sign-interpreted, so AW-bit addition with the carry discarded gives the result.
- CALL, with `sp`<DEPTH: push `pc`+1 mod 2^AW, then `sp` ← `sp`+1 and `pc` ← `target`.
- CALL, with `sp`=DEPTH: no push, `pc` and `sp` unchanged, `stack_ovf` ← 1.
- RET, with `sp`>0: `pc` ← top entry, then `sp` ← `sp`−1.
- RET, with `sp`=0: `pc` and `sp` unchanged, `stack_unf` ← 1.
- HOLD: no state change.
- `en`=0: `op` is ignored and all state holds. `clr_err` still acts.
- Stack is LIFO. Entries above `sp` are don't-care and are never observable.
- Error flags stay set until `rst` or `clr_err`=1.
- If `clr_err` and a new error occur in the same cycle, the error wins and the flag is 1 after the edge.

## Timing
- Reset (async assert): `pc`=RESET_ADDR, `sp`=0, `stack_ovf`=0, `stack_unf`=0. Stack contents are not reset.
- Reset asserted mid-operation discards any in-flight op. The first op after deassertion is evaluated at the first rising edge with `rst`=0.
- All outputs are registered. `op` and its operands are sampled at edge n, and the result is visible on `pc`/`sp`/flags after edge n, with 1-cycle latency.
- A CALL followed immediately by a RET on the next cycle returns to the pushed address with no bubble. The pushed value is visible to the RET at the next edge.
- There is no combinational path from inputs to outputs.

## Structure
- Package `pc_pkg`:
  - `pc_op_t`, a 3-bit enum: OP_INC, OP_JMP, OP_BR, OP_CALL, OP_RET, OP_HOLD.
  - Localparam `PC_OP_W`=3.
- Sub-module `pc_ret_stack`:
  - Parametrised LIFO (`AW`, `DEPTH`).
  - Ports: `push`, `pop`, `din`, `top`, `count`, `full`, `empty`. Same `clk`/`rst`.
  - Never receives push and pop in the same cycle.
- Top level `pc_stack`:
  - Next-pc mux with the one-cycle update, error flags, and op decode.
  - Gates push/pop using `full`/`empty`.

## Test plan
- Reset and increment: AW=5, RESET_ADDR=0, assert `rst`, then 33× INC → `pc` reads 1..31, 0, 1. `sp`=0 and the flags stay 0 throughout.
- Branch arithmetic: from `pc`=10, BR `offset`=5'b11101 (−3) → 7. From `pc`=30, BR `offset`=4 → 2 (wrap). JMP `target`=17 → 17.
- Nested calls: DEPTH=4, `pc`=3.
  - CALL 20 → `pc`=20, `sp`=1. CALL 25 → `pc`=25, `sp`=2.
  - RET → `pc`=21, `sp`=1. RET → `pc`=4, `sp`=0.
  - Back-to-back CALL/RET shows no bubble.
- Overflow and underflow:
  - 4 CALLs, then a 5th CALL → `pc` unchanged, `sp`=4, `stack_ovf`=1.
  - 4 RETs, then a 5th RET → `pc` unchanged, `stack_unf`=1.
  - `clr_err` → both flags 0 next cycle.
  - `clr_err` plus a simultaneous failing RET → `stack_unf` stays 1.
- Stall and reserved codes: `en`=0 with op=CALL for 3 cycles → `pc`, `sp` and the stack are unchanged. Op 6 or 7 with `en`=1 → held.
- Async reset mid-stream: assert `rst` between edges while `sp`=2 and `pc`=25 → `pc`=0, `sp`=0 and the flags clear immediately without a clock edge. A subsequent RET then sets `stack_unf`.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the patp program counter.
// Opcode encoding driven by decode into pc_stack.op. Codes 6 and 7 are
// left unnamed: the PC treats them as HOLD.
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        OP_INC  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HOLD = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_stack.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset (clears count only)
//   push, din - write din on top of the stack (caller guarantees !full)
//   pop       - discard the top entry (caller guarantees !empty)
//   top       - current top entry, readable combinationally so a RET in the
//               cycle right after a CALL sees the freshly pushed address
//   count     - number of valid entries, 0..DEPTH
//   full      - count == DEPTH
//   empty     - count == 0
// push and pop are never asserted together.
module pc_ret_stack
    import pc_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  din,
    output logic [AW-1:0]  top,
    output logic [SPW-1:0] count,
    output logic           full,
    output logic           empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] count_reg;
    logic [SPW-1:0] top_idx;

    // Top entry sits one below the count; only meaningful when !empty.
    assign top_idx = count_reg - SPW'(1);
    assign top     = mem[top_idx[IW-1:0]];
    assign count   = count_reg;
    assign full    = (count_reg == SPW'(DEPTH));
    assign empty   = (count_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (push) begin
            count_reg <= count_reg + SPW'(1);
        end else if (pop) begin
            count_reg <= count_reg - SPW'(1);
        end
    end

    // Entry storage is intentionally not reset; entries above count are
    // never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[count_reg[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack for the patp core.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   en        - advance enable; 0 stalls everything except clr_err
//   op        - operation (pc_op_t), codes 6/7 act as HOLD
//   target    - absolute address for JMP and CALL
//   offset    - two's-complement displacement for BR
//   clr_err   - clears the sticky error flags (a new error in the same
//               cycle takes priority)
//   pc        - current program counter (registered)
//   sp        - number of valid return-stack entries (registered)
//   stack_ovf - sticky: CALL issued while the stack was full
//   stack_unf - sticky: RET issued while the stack was empty
module pc_stack
    import pc_pkg::*;
#(
    parameter int          AW         = 5,
    parameter int          DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0,
    localparam int         SPW        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PC_OP_W-1:0] op,
    input  logic [AW-1:0]      target,
    input  logic [AW-1:0]      offset,
    input  logic               clr_err,
    output logic [AW-1:0]      pc,
    output logic [SPW-1:0]     sp,
    output logic               stack_ovf,
    output logic               stack_unf
);

    logic [AW-1:0]  pc_reg;
    logic [AW-1:0]  pc_next;
    logic [AW-1:0]  pc_inc;
    logic           ovf_reg;
    logic           unf_reg;
    logic           ovf_set;
    logic           unf_set;
    logic           push;
    logic           pop;
    logic [AW-1:0]  stack_top;
    logic [SPW-1:0] stack_count;
    logic           stack_full;
    logic           stack_empty;

    assign pc_inc = pc_reg + AW'(1);

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stack_top),
        .count (stack_count),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Op decode and next-pc selection. A CALL/RET that cannot touch the
    // stack leaves pc alone and only raises the matching error flag.
    always_comb begin
        pc_next = pc_reg;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en) begin
            case (pc_op_t'(op))
                OP_INC:  pc_next = pc_inc;
                OP_JMP:  pc_next = target;
                // Carry discarded: AW-bit add gives signed displacement.
                OP_BR:   pc_next = pc_reg + offset;
                OP_CALL: begin
                    if (stack_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_next = target;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_next = stack_top;
                    end
                end
                default: pc_next = pc_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= RESET_ADDR;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            ovf_reg <= ovf_set | (ovf_reg & ~clr_err);
            unf_reg <= unf_set | (unf_reg & ~clr_err);
        end
    end

    assign pc        = pc_reg;
    assign sp        = stack_count;
    assign stack_ovf = ovf_reg;
    assign stack_unf = unf_reg;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: stimulus drives ops on the falling edge and
// queues the reference model's expected state; a monitor compares after each
// rising edge.
module tb_pc_stack;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int MOD   = 1 << AW;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [2:0]     op;
    logic [AW-1:0]  target;
    logic [AW-1:0]  offset;
    logic           clr_err;
    logic [AW-1:0]  pc;
    logic [SPW-1:0] sp;
    logic           stack_ovf;
    logic           stack_unf;

    pc_stack #(
        .AW         (AW),
        .DEPTH      (DEPTH),
        .RESET_ADDR (5'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .clr_err   (clr_err),
        .pc        (pc),
        .sp        (sp),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int sp;
        int ovf;
        int unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;

    // Reference model: plain integers and a queue used as the LIFO.
    int m_pc;
    int m_ovf;
    int m_unf;
    int m_stack[$];

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_ovf = 0;
        m_unf = 0;
        m_stack.delete();
    endtask

    task automatic model_step(input bit e, input int o, input int tgt,
                              input int off, input bit c);
        int n_ovf;
        int n_unf;
        int soff;
        n_ovf = c ? 0 : m_ovf;
        n_unf = c ? 0 : m_unf;
        if (e) begin
            case (o)
                0: m_pc = (m_pc + 1) % MOD;
                1: m_pc = tgt;
                2: begin
                    soff = (off >= MOD / 2) ? off - MOD : off;
                    m_pc = (m_pc + soff + MOD) % MOD;
                end
                3: begin
                    if (m_stack.size() < DEPTH) begin
                        m_stack.push_back((m_pc + 1) % MOD);
                        m_pc = tgt;
                    end else begin
                        n_ovf = 1;
                    end
                end
                4: begin
                    if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else n_unf = 1;
                end
                default: ;
            endcase
        end
        m_ovf = n_ovf;
        m_unf = n_unf;
    endtask

    // One transaction: drive on the falling edge, queue expected result.
    task automatic step(input bit e, input int o, input int tgt, input int off,
                        input bit c);
        exp_t x;
        int   t;
        int   f;
        t = tgt;
        f = off;
        @(negedge clk);
        en      = e;
        op      = o[2:0];
        target  = t[AW-1:0];
        offset  = f[AW-1:0];
        clr_err = c;
        model_step(e, o, t % MOD, f & (MOD - 1), c);
        x.pc  = m_pc;
        x.sp  = m_stack.size();
        x.ovf = m_ovf;
        x.unf = m_unf;
        exp_q.push_back(x);
    endtask

    // Monitor: the DUT presents a new state after every rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            n_txn++;
            chk("pc", int'(pc), x.pc);
            chk("sp", int'(sp), x.sp);
            chk("stack_ovf", int'(stack_ovf), x.ovf);
            chk("stack_unf", int'(stack_unf), x.unf);
            $display("[TB] txn %0d op=%0d en=%0b pc=%0d sp=%0d ovf=%0b unf=%0b",
                     n_txn, op, en, pc, sp, stack_ovf, stack_unf);
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, int'(pc), 0);
        chk({tag, "_sp"}, int'(sp), 0);
        chk({tag, "_ovf"}, int'(stack_ovf), 0);
        chk({tag, "_unf"}, int'(stack_unf), 0);
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        op      = 3'd0;
        target  = '0;
        offset  = '0;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Increment and wrap.
        repeat (33) step(1, 0, 0, 0, 0);

        // Branch arithmetic.
        step(1, 1, 10, 0, 0);
        step(1, 2, 0, -3, 0);
        step(1, 1, 30, 0, 0);
        step(1, 2, 0, 4, 0);
        step(1, 1, 17, 0, 0);

        // Nested calls and back-to-back CALL/RET.
        step(1, 1, 3, 0, 0);
        step(1, 3, 20, 0, 0);
        step(1, 3, 25, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 3, 12, 0, 0);
        step(1, 4, 0, 0, 0);

        // Overflow, underflow, clear, clear racing a new error.
        for (int i = 0; i < 5; i++) step(1, 3, 8 + i, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 4, 0, 0, 0);
        step(1, 5, 0, 0, 1);
        step(1, 4, 0, 0, 0);
        step(1, 4, 0, 0, 1);
        step(1, 5, 0, 0, 1);

        // Stall with CALL pending, then reserved opcodes.
        step(1, 3, 14, 0, 0);
        repeat (3) step(0, 3, 22, 0, 0);
        step(1, 6, 9, 9, 0);
        step(1, 7, 9, 9, 0);
        step(1, 4, 0, 0, 0);

        // Async reset between edges while sp=2, pc=25.
        step(1, 1, 3, 0, 0);
        step(1, 3, 20, 0, 0);
        step(1, 3, 25, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        model_reset();
        #1;
        rst = 1'b0;
        step(1, 4, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            int o;
            r = $urandom_range(0, 99);
            if (r < 20) o = 0;
            else if (r < 30) o = 1;
            else if (r < 42) o = 2;
            else if (r < 64) o = 3;
            else if (r < 86) o = 4;
            else o = $urandom_range(5, 7);
            step($urandom_range(0, 9) != 0, o, $urandom_range(0, MOD - 1),
                 $urandom_range(0, MOD - 1), $urandom_range(0, 19) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
